mc_control_fsm: RTL and testbench

Multicycle main control unit for the MIPS datapath: a Moore-style state machine that walks each instruction through fetch, decode, execute, memory and writeback. It generates every select line for the datapath's 2:1 and 4:1 multiplexers, plus the register and memory enables. It sits directly upstream of those multiplexers and waits on a memory ready handshake.

---
 rtl/mc_control_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: walks each instruction through fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 cycles; state-only selects registered with the state.
// Backpressure: a low mem_ready in FETCH, MEMRD or MEMWR holds the state and every output for that cycle.
module mc_control_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_retire,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_RTYPEEX = 4'd7,
      S_RTYPEWB = 4'd8,
      S_BEQEX   = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JEX     = 4'd12
   } state_t;

   // Selects and strobes that depend on the state alone; registered alongside it.
   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       pc_write;
      logic       pc_write_cond;
   } ctrl_t;

   state_t r_state;
   ctrl_t  r_ctrl;
   logic   r_is_sw;
   logic   r_illegal;

   state_t w_nxt;
   logic   w_legal;

   // Moore output table; unlisted states (including RESET) drive everything low.
   function automatic ctrl_t f_decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_RTYPEEX: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_RTYPEWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BEQEX: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_src        = 2'b01;
            c.pc_write_cond = 1'b1;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_ADDIWB:  c.reg_write = 1'b1;
         S_JEX: begin
            c.pc_src   = 2'b10;
            c.pc_write = 1'b1;
         end
         default:   c = '0;
      endcase
      return c;
   endfunction

   // Recognise the six supported opcodes.
   always_comb begin
      w_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
         default:                                     w_legal = 1'b0;
      endcase
   end

   // Next-state logic; op is only looked at in DECODE, the lw/sw choice is latched there.
   always_comb begin
      w_nxt = S_FETCH;
      case (r_state)
         S_RESET:   w_nxt = S_FETCH;
         S_FETCH:   w_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_nxt = S_MEMADR;
               OP_RTYP:      w_nxt = S_RTYPEEX;
               OP_BEQ:       w_nxt = S_BEQEX;
               OP_ADDI:      w_nxt = S_ADDIEX;
               OP_J:         w_nxt = S_JEX;
               default:      w_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:  w_nxt = r_is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   w_nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: w_nxt = S_RTYPEWB;
         S_ADDIEX:  w_nxt = S_ADDIWB;
         default:   w_nxt = S_FETCH;
      endcase
   end

   // State register with its registered outputs, lw/sw latch and sticky illegal flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RESET;
         r_ctrl    <= '0;
         r_is_sw   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_ctrl  <= f_decode(w_nxt);
         if (r_state == S_DECODE) begin
            r_is_sw <= (op == OP_SW);
            if (!w_legal)
               r_illegal <= 1'b1;
         end
      end
   end

   // Handshake-dependent enables stay combinational so they act in the same cycle.
   always_comb begin
      ir_write     = (r_state == S_FETCH) && mem_ready;
      pc_en        = ((r_state == S_FETCH) && mem_ready) || r_ctrl.pc_write ||
                     (r_ctrl.pc_write_cond && zero);
      instr_retire = (r_state == S_MEMWB) || (r_state == S_RTYPEWB) ||
                     (r_state == S_BEQEX) || (r_state == S_ADDIWB) ||
                     (r_state == S_JEX) ||
                     ((r_state == S_MEMWR) && mem_ready) ||
                     ((r_state == S_DECODE) && !w_legal);
   end

   assign iord       = r_ctrl.iord;
   assign mem_read   = r_ctrl.mem_read;
   assign mem_write  = r_ctrl.mem_write;
   assign reg_dst    = r_ctrl.reg_dst;
   assign mem_to_reg = r_ctrl.mem_to_reg;
   assign reg_write  = r_ctrl.reg_write;
   assign alu_src_a  = r_ctrl.alu_src_a;
   assign alu_src_b  = r_ctrl.alu_src_b;
   assign alu_op     = r_ctrl.alu_op;
   assign pc_src     = r_ctrl.pc_src;
   assign illegal_op = r_illegal;
   assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction sequences, expected outputs queued per cycle.
// A monitor pops one expectation per cycle on the falling edge and compares the full output vector.
// Expectations come from a hand-written table of the control values each state must drive.
module tb_mc_control_fsm;

   localparam logic [5:0] L = 6'b100011;
   localparam logic [5:0] S = 6'b101011;
   localparam logic [5:0] R = 6'b000000;
   localparam logic [5:0] B = 6'b000100;
   localparam logic [5:0] A = 6'b001000;
   localparam logic [5:0] J = 6'b000010;
   localparam logic [5:0] X = 6'b111111;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, instr_retire, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   typedef struct {
      logic [20:0] v;
      int          id;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_cyc    = 0;

   mc_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .instr_retire(instr_retire),
      .illegal_op(illegal_op), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector for one cycle:
   // {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
   //  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_retire, illegal_op}
   function automatic logic [20:0] expv(input int st, input logic [5:0] o,
                                        input logic mr, input logic z, input logic ill);
      logic pe, io, rd, wr, irw, rdst, m2r, rw, asa, ret;
      logic [1:0] asb, aop, psrc;
      pe = 0; io = 0; rd = 0; wr = 0; irw = 0; rdst = 0; m2r = 0; rw = 0;
      asa = 0; ret = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         1:  begin rd = 1; asb = 2'b01; irw = mr; pe = mr; end
         2:  begin
                asb = 2'b11;
                ret = !(o == L || o == S || o == R || o == B || o == A || o == J);
             end
         3:  begin asa = 1; asb = 2'b10; end
         4:  begin io = 1; rd = 1; end
         5:  begin m2r = 1; rw = 1; ret = 1; end
         6:  begin io = 1; wr = 1; ret = mr; end
         7:  begin asa = 1; aop = 2'b10; end
         8:  begin rdst = 1; rw = 1; ret = 1; end
         9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pe = z; ret = 1; end
         10: begin asa = 1; asb = 2'b10; end
         11: begin rw = 1; ret = 1; end
         12: begin psrc = 2'b10; pe = 1; ret = 1; end
         default: ;
      endcase
      return {st[3:0], pe, io, rd, wr, irw, rdst, m2r, rw, asa, asb, aop, psrc, ret, ill};
   endfunction

   // One clock cycle: drive inputs, queue what the DUT must show this cycle, advance.
   task automatic c(input int st, input logic [5:0] o, input logic mr,
                    input logic z, input logic ill);
      exp_t e;
      op        = o;
      mem_ready = mr;
      zero      = z;
      e.v  = expv(st, o, mr, z, ill);
      e.id = n_cyc;
      q.push_back(e);
      n_cyc++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation, away from the rising edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [20:0] act;
         e   = q.pop_front();
         act = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_retire, illegal_op};
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL cycle%0d outputs got=%h exp=%h (state got=%0d exp=%0d)",
                     e.id, act, e.v, act[20:17], e.v[20:17]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; op = R; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset held across three edges, then the release cycle still in RESET.
      c(0, R, 1, 1, 0); c(0, L, 1, 1, 0); c(0, J, 1, 0, 0);
      rst_n = 1'b1;
      c(0, R, 1, 0, 0);
      // lw with one MEMRD wait; op changed to sw in MEMADR must not matter.
      c(1, L, 1, 0, 0); c(2, L, 1, 0, 0); c(3, S, 1, 0, 0);
      c(4, S, 0, 0, 0); c(4, S, 1, 0, 0); c(5, S, 1, 0, 0);
      // lw zero wait: 5 cycles.
      c(1, L, 1, 0, 0); c(2, L, 1, 0, 0); c(3, L, 1, 0, 0); c(4, L, 1, 0, 0); c(5, L, 1, 0, 0);
      // sw with two MEMWR waits; op changed to lw in MEMADR.
      c(1, S, 1, 0, 0); c(2, S, 1, 0, 0); c(3, L, 1, 0, 0);
      c(6, S, 0, 0, 0); c(6, S, 0, 0, 0); c(6, S, 1, 0, 0);
      // beq taken then not taken.
      c(1, B, 1, 0, 0); c(2, B, 1, 0, 0); c(9, B, 1, 1, 0);
      c(1, B, 1, 1, 0); c(2, B, 1, 1, 0); c(9, B, 1, 0, 0);
      // Fetch stall of 4 cycles, then R-type; mem_ready low in execute is ignored.
      c(1, R, 0, 0, 0); c(1, R, 0, 0, 0); c(1, R, 0, 0, 0); c(1, R, 0, 0, 0);
      c(1, R, 1, 0, 0); c(2, R, 1, 0, 0); c(7, R, 0, 0, 0); c(8, R, 0, 0, 0);
      // addi.
      c(1, A, 1, 0, 0); c(2, A, 1, 0, 0); c(10, A, 0, 0, 0); c(11, A, 1, 0, 0);
      // Illegal opcode: back to FETCH, flag sticks through the following j.
      c(1, X, 1, 0, 0); c(2, X, 1, 0, 0);
      c(1, J, 1, 0, 1); c(2, J, 1, 0, 1); c(12, J, 1, 0, 1);
      // Second j, reset asserted mid-JEX clears everything without a clock edge.
      c(1, J, 1, 0, 1); c(2, J, 1, 0, 1);
      rst_n = 1'b0;
      c(0, J, 1, 1, 0); c(0, J, 1, 1, 0);
      rst_n = 1'b1;
      c(0, L, 1, 0, 0);
      c(1, L, 1, 0, 0); c(2, L, 1, 0, 0);
      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
